// File: rtl/ram_stream_reader.sv
// ram_stream_reader
// Read-side controller for a single-clock use of the dual-clock `ram` block.
// Takes a burst command (base address, word count), issues read strobes,
// absorbs the RAM's one-cycle read latency and delivers the words in address
// order on a valid/ready stream with full backpressure.
//
// Ports
//   clk, rst                 : clock, asynchronous active-high reset
//   start, base_addr, len    : burst request; sampled only while busy is low
//   busy, done               : burst in progress / one-cycle completion pulse
//   ram_rden, ram_rdaddr     : read strobe and address to the RAM read port
//   ram_rddata               : RAM read data, valid the cycle after a strobe
//   m_valid, m_ready, m_data : output stream
//   dbg_state                : current FSM state (0 IDLE, 1 READ, 2 DRAIN)
//
// Handshake: a word transfers on every rising edge where m_valid and m_ready
// are both high; m_valid/m_data hold steady while m_valid && !m_ready.
module ram_stream_reader #(
    parameter  int WIDTH = 64,
    parameter  int SIZE  = 512,
    localparam int ABITS = $clog2(SIZE)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [ABITS-1:0] base_addr,
    input  logic [ABITS:0]   len,
    output logic             busy,
    output logic             done,
    output logic             ram_rden,
    output logic [ABITS-1:0] ram_rdaddr,
    input  logic [WIDTH-1:0] ram_rddata,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [WIDTH-1:0] m_data,
    output logic [1:0]       dbg_state
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_READ  = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [ABITS-1:0] addr_q, addr_d;
    logic [ABITS:0]   issue_q, issue_d;
    logic [ABITS:0]   deliv_q, deliv_d;
    logic             inflight_q;
    logic             done_q, done_d;
    logic [WIDTH-1:0] head_q, head_d;
    logic [WIDTH-1:0] tail_q, tail_d;
    logic [1:0]       count_q, count_d;

    logic pop;
    logic push;
    logic rden;

    assign pop  = (count_q != 2'd0) && m_ready;
    // A word lands in the buffer exactly one cycle after its read edge, never
    // otherwise: the RAM holds rddata while rden is low.
    assign push = inflight_q;

    // Credit: occupancy + inflight - pop < 2, rearranged to avoid underflow.
    assign rden = (state_q == S_READ) &&
                  (({1'b0, count_q} + {2'b00, inflight_q}) < (3'd2 + {2'b00, pop}));

    // Control FSM and counters
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        issue_d = issue_q;
        deliv_d = deliv_q;
        done_d  = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (len != '0) begin
                        state_d = S_READ;
                        addr_d  = base_addr;
                        issue_d = len;
                        deliv_d = len;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            S_READ: begin
                if (rden) begin
                    // Explicit compare so the wrap is correct for non-power-of-2 SIZE.
                    addr_d  = (addr_q == ABITS'(SIZE - 1)) ? '0 : addr_q + ABITS'(1);
                    issue_d = issue_q - (ABITS+1)'(1);
                    if (issue_q == (ABITS+1)'(1)) begin
                        state_d = S_DRAIN;
                    end
                end
            end
            default: ;
        endcase

        // The final pop can only happen once every read has been issued.
        if ((state_q != S_IDLE) && pop) begin
            deliv_d = deliv_q - (ABITS+1)'(1);
            if (deliv_q == (ABITS+1)'(1)) begin
                state_d = S_IDLE;
                done_d  = 1'b1;
            end
        end
    end

    // Two-entry output buffer; head register drives m_data directly.
    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;

        case (count_q)
            2'd0: begin
                if (push) begin
                    head_d  = ram_rddata;
                    count_d = 2'd1;
                end
            end
            2'd1: begin
                if (push && pop) begin
                    head_d = ram_rddata;
                end else if (push) begin
                    tail_d  = ram_rddata;
                    count_d = 2'd2;
                end else if (pop) begin
                    count_d = 2'd0;
                end
            end
            default: begin
                // The credit rule forbids a push into a full buffer without a pop.
                if (pop) begin
                    head_d = tail_q;
                    if (push) begin
                        tail_d = ram_rddata;
                    end else begin
                        count_d = 2'd1;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            addr_q     <= '0;
            issue_q    <= '0;
            deliv_q    <= '0;
            inflight_q <= 1'b0;
            done_q     <= 1'b0;
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= 2'd0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            issue_q    <= issue_d;
            deliv_q    <= deliv_d;
            inflight_q <= rden;
            done_q     <= done_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
            count_q    <= count_d;
        end
    end

    assign busy       = (state_q != S_IDLE);
    assign done       = done_q;
    assign ram_rden   = rden;
    assign ram_rdaddr = addr_q;
    assign m_valid    = (count_q != 2'd0);
    assign m_data     = head_q;
    assign dbg_state  = state_q;

endmodule

// File: tb/tb_ram_stream_reader.sv
module tb_ram_stream_reader;

    localparam int WIDTH  = 64;
    localparam int SIZE   = 512;
    localparam int ABITS  = 9;
    localparam int SIZE_B = 500;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // ---------------- DUT A (SIZE 512) ----------------
    logic             start;
    logic [ABITS-1:0] base_addr;
    logic [ABITS:0]   len;
    logic             busy, done, ram_rden, m_valid, m_ready;
    logic [ABITS-1:0] ram_rdaddr;
    logic [WIDTH-1:0] ram_rddata = '0;
    logic [WIDTH-1:0] m_data;
    logic [1:0]       dbg_state;

    ram_stream_reader #(.WIDTH(WIDTH), .SIZE(SIZE)) dut (
        .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .len(len),
        .busy(busy), .done(done), .ram_rden(ram_rden), .ram_rdaddr(ram_rdaddr),
        .ram_rddata(ram_rddata), .m_valid(m_valid), .m_ready(m_ready),
        .m_data(m_data), .dbg_state(dbg_state)
    );

    // ---------------- DUT B (SIZE 500, wrap check) ----------------
    logic             start_b;
    logic [ABITS-1:0] base_b;
    logic [ABITS:0]   len_b;
    logic             busy_b, done_b, ram_rden_b, m_valid_b;
    logic             m_ready_b = 1'b1;
    logic [ABITS-1:0] ram_rdaddr_b;
    logic [WIDTH-1:0] ram_rddata_b = '0;
    logic [WIDTH-1:0] m_data_b;
    logic [1:0]       dbg_state_b;

    ram_stream_reader #(.WIDTH(WIDTH), .SIZE(SIZE_B)) dut_b (
        .clk(clk), .rst(rst), .start(start_b), .base_addr(base_b), .len(len_b),
        .busy(busy_b), .done(done_b), .ram_rden(ram_rden_b), .ram_rdaddr(ram_rdaddr_b),
        .ram_rddata(ram_rddata_b), .m_valid(m_valid_b), .m_ready(m_ready_b),
        .m_data(m_data_b), .dbg_state(dbg_state_b)
    );

    // RAM contents: a marker in the top bits so real words never look like reset zeros.
    function automatic logic [WIDTH-1:0] mem_val(input int a);
        return {16'hC0DE, 16'h0000, 32'(a)};
    endfunction

    // RAM read-port models: one-cycle latency, data held while rden is low.
    always @(posedge clk) if (ram_rden) ram_rddata <= mem_val(int'(ram_rdaddr));
    always @(posedge clk) if (ram_rden_b) ram_rddata_b <= mem_val(int'(ram_rdaddr_b));

    // ---------------- scoreboard state ----------------
    logic [WIDTH-1:0] exp_q[$];
    logic [WIDTH-1:0] expb_d[$];
    int               expb_a[$];
    int checks = 0;
    int errors = 0;
    int ready_pct = 100;
    int exp_addr = 0;
    int rden_cnt = 0;
    int done_cnt = 0;
    int pop_cnt  = 0;
    int occ = 0;
    int infl = 0;
    bit stall_prev = 0;
    logic [WIDTH-1:0] prev_data = '0;

    typedef struct {
        int   base;
        int   len;
        int   ready_pct;
        logic exp_busy;
        int   exp_rden;
    } vec_t;

    localparam int NV = 7;
    vec_t vecs[NV];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_reset(input string tag);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_rden"}, ram_rden, 0);
        chk({tag, "_rdaddr"}, ram_rdaddr, 0);
        chk({tag, "_m_valid"}, m_valid, 0);
        chk({tag, "_m_data"}, m_data, 0);
        chk({tag, "_state"}, dbg_state, 0);
    endtask

    // ---------------- m_ready driver ----------------
    initial begin
        m_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            m_ready = ($urandom_range(0, 99) < ready_pct);
        end
    end

    // ---------------- monitor (samples at negedge) ----------------
    always @(negedge clk) begin
        logic pop;
        if (rst) begin
            occ = 0;
            infl = 0;
            stall_prev = 0;
        end else begin
            pop = m_valid && m_ready;
            chk("m_valid_vs_occ", m_valid, (occ > 0));
            if (stall_prev) begin
                chk("stall_valid", m_valid, 1);
                chk("stall_data", m_data, prev_data);
            end
            if (ram_rden) begin
                rden_cnt++;
                checks++;
                if (occ + infl - int'(pop) >= 2) begin
                    errors++;
                    $display("FAIL credit: rden with occ=%0d infl=%0d pop=%0d", occ, infl, pop);
                end
                chk("rdaddr", ram_rdaddr, exp_addr);
                exp_addr = (exp_addr == SIZE - 1) ? 0 : exp_addr + 1;
            end
            if (pop) begin
                pop_cnt++;
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL extra_word: got %0h expected none", m_data);
                end else begin
                    logic [WIDTH-1:0] e;
                    e = exp_q.pop_front();
                    if (m_data !== e) begin
                        errors++;
                        $display("FAIL word: got %0h expected %0h", m_data, e);
                    end
                end
            end
            if (done) done_cnt++;
            occ = occ + infl - int'(pop);
            infl = int'(ram_rden);
            checks++;
            if (occ > 2) begin
                errors++;
                $display("FAIL occupancy: got %0d expected <=2", occ);
            end
            stall_prev = m_valid && !m_ready;
            prev_data = m_data;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic clear_counts();
        rden_cnt = 0;
        done_cnt = 0;
        pop_cnt = 0;
    endtask

    task automatic start_cmd(input int b, input int n);
        base_addr = ABITS'(b);
        len = (ABITS+1)'(n);
        start = 1'b1;
        exp_addr = b;
        for (int i = 0; i < n; i++) exp_q.push_back(mem_val((b + i) % SIZE));
    endtask

    task automatic wait_done(input int limit, output int cyc);
        cyc = -1;
        for (int k = 1; k <= limit; k++) begin
            @(posedge clk);
            #1;
            if (done) begin
                cyc = k;
                break;
            end
        end
        checks++;
        if (cyc < 0) begin
            errors++;
            $display("FAIL done_timeout: got no done expected done within %0d cycles", limit);
        end
    endtask

    task automatic run_burst(input vec_t v);
        int cyc;
        ready_pct = v.ready_pct;
        clear_counts();
        start_cmd(v.base, v.len);
        @(posedge clk);
        #1;
        start = 1'b0;
        chk("busy_after_start", busy, v.exp_busy);
        if (v.len == 0) begin
            chk("zero_len_done", done, 1);
            chk("zero_len_valid", m_valid, 0);
            chk("zero_len_rden", ram_rden, 0);
            @(posedge clk);
            #1;
            chk("zero_len_done_clear", done, 0);
        end else begin
            chk("rdaddr_after_start", ram_rdaddr, v.base);
            chk("valid_e0", m_valid, 0);
            @(posedge clk);
            #1;
            chk("valid_e1", m_valid, 0);
            @(posedge clk);
            #1;
            chk("valid_e2", m_valid, 1);
            wait_done(4 * v.len + 50, cyc);
            if (v.ready_pct == 100) chk("done_edge", cyc + 2, v.len + 2);
            chk("busy_in_done", busy, 0);
            @(posedge clk);
            #1;
            chk("done_one_cycle", done, 0);
        end
        chk("exp_q_empty", exp_q.size(), 0);
        chk("rden_count", rden_cnt, v.exp_rden);
        chk("done_count", done_cnt, 1);
    endtask

    task automatic run_b(input int b, input int n);
        int a;
        bit seen;
        a = b;
        expb_d.delete();
        expb_a.delete();
        for (int i = 0; i < n; i++) begin
            expb_a.push_back(a);
            expb_d.push_back(mem_val(a));
            a = (a == SIZE_B - 1) ? 0 : a + 1;
        end
        base_b = ABITS'(b);
        len_b = (ABITS+1)'(n);
        start_b = 1'b1;
        @(posedge clk);
        #1;
        start_b = 1'b0;
        seen = 0;
        for (int k = 0; k < n + 20 && !seen; k++) begin
            @(negedge clk);
            if (ram_rden_b) begin
                checks++;
                if (expb_a.size() == 0) begin
                    errors++;
                    $display("FAIL b_extra_read: got addr %0d expected none", ram_rdaddr_b);
                end else if (int'(ram_rdaddr_b) != expb_a[0]) begin
                    errors++;
                    $display("FAIL b_addr: got %0d expected %0d", ram_rdaddr_b, expb_a[0]);
                    void'(expb_a.pop_front());
                end else begin
                    void'(expb_a.pop_front());
                end
            end
            if (m_valid_b) begin
                checks++;
                if (expb_d.size() == 0) begin
                    errors++;
                    $display("FAIL b_extra_word: got %0h expected none", m_data_b);
                end else begin
                    logic [WIDTH-1:0] e;
                    e = expb_d.pop_front();
                    if (m_data_b !== e) begin
                        errors++;
                        $display("FAIL b_word: got %0h expected %0h", m_data_b, e);
                    end
                end
            end
            if (done_b) seen = 1;
        end
        chk("b_done_seen", seen, 1);
        chk("b_addr_q_empty", expb_a.size(), 0);
        chk("b_data_q_empty", expb_d.size(), 0);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int cyc;
        int dc;
        vec_t v;

        vecs[0] = '{base: 10,  len: 4,   ready_pct: 100, exp_busy: 1'b1, exp_rden: 4};
        vecs[1] = '{base: 510, len: 4,   ready_pct: 100, exp_busy: 1'b1, exp_rden: 4};
        vecs[2] = '{base: 77,  len: 0,   ready_pct: 100, exp_busy: 1'b0, exp_rden: 0};
        vecs[3] = '{base: 100, len: 16,  ready_pct: 30,  exp_busy: 1'b1, exp_rden: 16};
        vecs[4] = '{base: 3,   len: 512, ready_pct: 100, exp_busy: 1'b1, exp_rden: 512};
        vecs[5] = '{base: 200, len: 7,   ready_pct: 60,  exp_busy: 1'b1, exp_rden: 7};
        vecs[6] = '{base: 505, len: 20,  ready_pct: 50,  exp_busy: 1'b1, exp_rden: 20};

        rst = 1'b1;
        start = 1'b0;
        base_addr = '0;
        len = '0;
        start_b = 1'b0;
        base_b = '0;
        len_b = '0;
        repeat (3) @(posedge clk);
        #1;
        check_reset("reset");
        rst = 1'b0;
        @(posedge clk);
        #1;

        for (int i = 0; i < NV; i++) run_burst(vecs[i]);

        // start pulsed mid-burst is ignored
        ready_pct = 70;
        clear_counts();
        start_cmd(50, 10);
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        base_addr = ABITS'(300);
        len = (ABITS+1)'(3);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_done(100, cyc);
        @(posedge clk);
        #1;
        chk("busy_start_rden", rden_cnt, 10);
        chk("busy_start_done", done_cnt, 1);
        chk("busy_start_q", exp_q.size(), 0);

        // back-to-back: new start accepted in the done cycle
        ready_pct = 100;
        clear_counts();
        start_cmd(20, 3);
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_done(40, cyc);
        start_cmd(30, 2);
        @(posedge clk);
        #1;
        start = 1'b0;
        chk("b2b_busy", busy, 1);
        chk("b2b_addr", ram_rdaddr, 30);
        wait_done(40, cyc);
        chk("b2b_done_edge", cyc, 4);
        @(posedge clk);
        #1;
        chk("b2b_done_count", done_cnt, 2);
        chk("b2b_rden_count", rden_cnt, 5);
        chk("b2b_q", exp_q.size(), 0);

        // wrap with non-power-of-2 depth
        run_b(498, 4);

        // async reset mid-burst
        ready_pct = 100;
        clear_counts();
        start_cmd(40, 8);
        @(posedge clk);
        #1;
        start = 1'b0;
        for (int k = 0; k < 50; k++) begin
            @(posedge clk);
            #1;
            if (pop_cnt >= 3) break;
        end
        chk("pops_before_reset", pop_cnt, 3);
        dc = done_cnt;
        #2;
        rst = 1'b1;
        #1;
        check_reset("mid_reset");
        exp_q.delete();
        @(posedge clk);
        #1;
        check_reset("held_reset");
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("no_done_after_reset", done_cnt, dc);
        chk("idle_after_reset", busy, 0);
        v = '{base: 0, len: 2, ready_pct: 100, exp_busy: 1'b1, exp_rden: 2};
        run_burst(v);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

endmodule
